// File: rtl/transition_detector_mc.sv
// Multi-channel all-zero/all-one transition detector with fixed-length detect
// pulses and per-channel saturating event counters.

module transition_detector_mc_lane #(
  parameter int W        = 2,
  parameter int MIN_IDLE = 2,
  parameter int HOLD     = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode_q,
  input  logic             clr_cnt,
  input  logic [W-1:0]     din,
  output logic             det,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] evt_cnt
);
  localparam int QW = $clog2(MIN_IDLE + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_QUAL = 2'd1, S_HOLD = 2'd2;
  localparam logic [1:0] M_RISE = 2'd0, M_FALL = 2'd1, M_BOTH = 2'd2;

  logic [QW-1:0] qual_cnt, qual_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [1:0]    state_nxt;
  logic          src, src_nxt;  // recorded source: 0 = all-zero, 1 = all-one
  logic          is_z, is_o, on_src, on_tgt, hit;

  assign is_z   = (din == '0);
  assign is_o   = &din;
  assign on_src = src ? is_o : is_z;
  assign on_tgt = src ? is_z : is_o;

  always_comb begin
    state_nxt = S_IDLE;
    qual_nxt  = qual_cnt;
    hold_nxt  = hold_cnt;
    src_nxt   = src;
    hit       = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_z && (mode_q == M_RISE || mode_q == M_BOTH)) begin
          state_nxt = S_QUAL;
          src_nxt   = 1'b0;
          qual_nxt  = QW'(1);
        end else if (is_o && (mode_q == M_FALL || mode_q == M_BOTH)) begin
          state_nxt = S_QUAL;
          src_nxt   = 1'b1;
          qual_nxt  = QW'(1);
        end
      end
      S_QUAL: begin
        if (on_src) begin
          state_nxt = S_QUAL;
          if (qual_cnt != QW'(MIN_IDLE)) qual_nxt = qual_cnt + QW'(1);
        end else if (on_tgt && qual_cnt >= QW'(MIN_IDLE)) begin
          state_nxt = S_HOLD;
          hold_nxt  = HW'(1);
          hit       = 1'b1;
        end else if (on_tgt && mode_q == M_BOTH) begin
          // a short run in "both" mode becomes the start of the opposite run
          state_nxt = S_QUAL;
          src_nxt   = ~src;
          qual_nxt  = QW'(1);
        end
      end
      S_HOLD: begin
        if (hold_cnt != HW'(HOLD)) begin
          state_nxt = S_HOLD;
          hold_nxt  = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!en) begin
      state_nxt = S_IDLE;
      hit       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      det      <= 1'b0;
      qual_cnt <= '0;
      hold_cnt <= '0;
      src      <= 1'b0;
      evt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      det      <= (state_nxt == S_HOLD);
      qual_cnt <= qual_nxt;
      hold_cnt <= hold_nxt;
      src      <= src_nxt;
      if (clr_cnt)                    evt_cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && evt_cnt != '1)  evt_cnt <= evt_cnt + CNT_W'(1);
    end
  end
endmodule

module transition_detector_mc #(
  parameter int CH       = 4,
  parameter int W        = 2,
  parameter int MIN_IDLE = 2,
  parameter int HOLD     = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                clr_cnt,
  input  logic [CH*W-1:0]     din,
  output logic [CH-1:0]       det,
  output logic                det_any,
  output logic [2*CH-1:0]     state,
  output logic [CH*CNT_W-1:0] evt_cnt
);
  logic [1:0] mode_q;

  // mode only moves while detection is disabled, so lanes never see it change mid-sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     mode_q <= 2'b00;
    else if (!en) mode_q <= mode;
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    transition_detector_mc_lane #(
      .W(W), .MIN_IDLE(MIN_IDLE), .HOLD(HOLD), .CNT_W(CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode_q  (mode_q),
      .clr_cnt (clr_cnt),
      .din     (din[c*W +: W]),
      .det     (det[c]),
      .state   (state[2*c +: 2]),
      .evt_cnt (evt_cnt[c*CNT_W +: CNT_W])
    );
  end

  assign det_any = |det;
endmodule

// File: tb/tb_transition_detector_mc.sv
// Randomized and directed bench for transition_detector_mc against a
// run-length/countdown reference model.

module tb_transition_detector_mc;
  localparam int CH = 4, W = 2, MIN_IDLE = 2, HOLD = 3, CNT_W = 4;
  localparam logic [7:0] NEU = 8'b01010101;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             clr_cnt = 1'b0;
  logic [CH*W-1:0]  din = NEU;
  logic [CH-1:0]    det;
  logic             det_any;
  logic [2*CH-1:0]  state;
  logic [CH*CNT_W-1:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: length of current source run, remaining pulse cycles, event count
  int   m_run[CH], m_src[CH], m_hold[CH], m_cnt[CH];
  logic [1:0] m_mode;

  transition_detector_mc #(
    .CH(CH), .W(W), .MIN_IDLE(MIN_IDLE), .HOLD(HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .clr_cnt(clr_cnt), .din(din),
    .det(det), .det_any(det_any), .state(state), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_src[c] = 0; m_hold[c] = 0; m_cnt[c] = 0;
    end
    m_mode = 2'b00;
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      logic [1:0] v;
      logic z, o, on_src, on_tgt, ev;
      v = din[c*W +: W];
      z = (v == 2'b00);
      o = (v == 2'b11);
      ev = 1'b0;
      on_src = m_src[c] ? o : z;
      on_tgt = m_src[c] ? z : o;
      if (!en) begin
        m_run[c] = 0; m_hold[c] = 0;
      end else if (m_hold[c] > 0) begin
        m_hold[c]--;
      end else if (m_run[c] > 0) begin
        if (on_src) m_run[c]++;
        else if (on_tgt && m_run[c] >= MIN_IDLE) begin
          m_run[c] = 0; m_hold[c] = HOLD; ev = 1'b1;
        end else if (on_tgt && m_mode == 2'b10) begin
          m_src[c] = 1 - m_src[c]; m_run[c] = 1;
        end else m_run[c] = 0;
      end else begin
        if (z && (m_mode == 2'b00 || m_mode == 2'b10)) begin m_run[c] = 1; m_src[c] = 0; end
        else if (o && (m_mode == 2'b01 || m_mode == 2'b10)) begin m_run[c] = 1; m_src[c] = 1; end
      end
      if (clr_cnt) m_cnt[c] = ev ? 1 : 0;
      else if (ev && m_cnt[c] < (1 << CNT_W) - 1) m_cnt[c]++;
    end
    if (!en) m_mode = mode;
  endtask

  function automatic logic [CH-1:0] exp_det();
    for (int c = 0; c < CH; c++) exp_det[c] = (m_hold[c] > 0);
  endfunction

  function automatic logic [2*CH-1:0] exp_state();
    for (int c = 0; c < CH; c++)
      exp_state[2*c +: 2] = (m_hold[c] > 0) ? 2'd2 : (m_run[c] > 0) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [CH*CNT_W-1:0] exp_cnt();
    for (int c = 0; c < CH; c++) exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
  endfunction

  task automatic step(input logic e, input logic [1:0] md, input logic cc, input logic [7:0] d);
    en = e; mode = md; clr_cnt = cc; din = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (det !== '0 || det_any !== 1'b0 || state !== '0 || evt_cnt !== '0) begin
      errors++;
      $display("FAIL reset: det=%b det_any=%b state=%b cnt=%h, want all zero", det, det_any, state, evt_cnt);
    end
    model_reset();
    rst = 1'b1;
    step(1'b0, 2'b00, 1'b0, NEU);
  endtask

  task automatic test_rise_basic();
    logic [7:0] seq [6];
    logic       want [6];
    seq  = '{{6'b010101, 2'b00}, {6'b010101, 2'b00}, {6'b010101, 2'b11}, NEU, NEU, NEU};
    want = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b00, 1'b0, seq[i]);
      checks++;
      if (det !== {3'b000, want[i]} || det_any !== want[i] || det !== exp_det() || state !== exp_state()) begin
        errors++;
        $display("FAIL rise_basic edge %0d: det=%b any=%b state=%b, want det0=%b model det=%b state=%b",
                 i + 1, det, det_any, state, want[i], exp_det(), exp_state());
      end
    end
    checks++;
    if (evt_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL rise_basic count: got %h want 0001", evt_cnt);
    end
  endtask

  task automatic test_qualification();
    logic [1:0] seq [13];
    int pulses = 0;
    seq = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 2'b00, 1'b0, {6'b010101, seq[i]});
      if (det[0]) pulses++;
      checks++;
      if (det !== exp_det() || state !== exp_state() || evt_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL qualification step %0d: det=%b state=%b cnt=%h, want %b %b %h",
                 i, det, state, evt_cnt, exp_det(), exp_state(), exp_cnt());
      end
    end
    checks++;
    if (pulses != 3 || evt_cnt[3:0] !== 4'd2) begin
      errors++;
      $display("FAIL qualification pulse: cycles=%0d cnt0=%0d, want 3 and 2", pulses, evt_cnt[3:0]);
    end
  endtask

  task automatic test_fall_both();
    logic [1:0] fseq [6];
    logic [1:0] bseq [8];
    int p1 = 0, p2 = 0, poff = 0;
    fseq = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01};
    step(1'b0, 2'b01, 1'b0, NEU);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b01, 1'b0, {4'b0101, fseq[i], 2'b01});
      if (det[1]) p1++;
      checks++;
      if (det !== exp_det() || state !== exp_state()) begin
        errors++;
        $display("FAIL fall step %0d: det=%b state=%b, want %b %b", i, det, state, exp_det(), exp_state());
      end
    end
    checks++;
    if (p1 != 3 || evt_cnt[7:4] !== 4'd1) begin
      errors++;
      $display("FAIL fall pulse: cycles=%0d cnt1=%0d, want 3 and 1", p1, evt_cnt[7:4]);
    end
    // both mode with a restart, then a mode change attempted while enabled
    bseq = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
    step(1'b0, 2'b10, 1'b0, NEU);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b10, 1'b0, {2'b01, bseq[i], 4'b0101});
      if (det[2]) p2++;
    end
    checks++;
    if (p2 != 3 || evt_cnt[11:8] !== 4'd1) begin
      errors++;
      $display("FAIL both pulse: cycles=%0d cnt2=%0d, want 3 and 1", p2, evt_cnt[11:8]);
    end
    p2 = 0;
    bseq = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b11, 1'b0, {2'b01, bseq[i], 4'b0101});
      if (det[2]) p2++;
    end
    checks++;
    if (p2 != 3 || det !== exp_det() || evt_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL mode_ignored: cycles=%0d cnt=%h, want 3 and %h", p2, evt_cnt, exp_cnt());
    end
    step(1'b0, 2'b11, 1'b0, NEU);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 2'b11, 1'b0, (i % 6 < 2) ? 8'h00 : (i % 6 < 4) ? 8'hFF : 8'h00);
      if (det !== '0) poff++;
    end
    checks++;
    if (poff != 0 || state !== '0) begin
      errors++;
      $display("FAIL mode_off: det cycles=%0d state=%b, want 0 and 0", poff, state);
    end
  endtask

  task automatic test_saturation_clear();
    logic [1:0] seq [6];
    seq = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01};
    step(1'b0, 2'b00, 1'b0, NEU);
    for (int e = 0; e < 16; e++)
      for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 1'b0, {seq[i], 6'b010101});
    checks++;
    if (evt_cnt[15:12] !== 4'd15 || evt_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL saturation: cnt3=%0d want 15", evt_cnt[15:12]);
    end
    step(1'b1, 2'b00, 1'b0, {2'b00, 6'b010101});
    step(1'b1, 2'b00, 1'b0, {2'b00, 6'b010101});
    step(1'b1, 2'b00, 1'b1, {2'b11, 6'b010101});
    checks++;
    if (evt_cnt[15:12] !== 4'd1 || det[3] !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_det: cnt3=%0d det3=%b want 1 and 1", evt_cnt[15:12], det[3]);
    end
    step(1'b1, 2'b00, 1'b0, NEU);
    step(1'b1, 2'b00, 1'b1, NEU);
    checks++;
    if (evt_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL clr_alone: cnt=%h want 0000", evt_cnt);
    end
    step(1'b1, 2'b00, 1'b0, NEU);
  endtask

  task automatic test_multi_channel();
    step(1'b1, 2'b00, 1'b0, 8'h00);
    step(1'b1, 2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b00, 1'b0, (i == 0) ? 8'hFF : NEU);
      checks++;
      if (det !== ((i < 3) ? 4'hF : 4'h0) || det_any !== (i < 3) || evt_cnt !== 16'h1111) begin
        errors++;
        $display("FAIL multi_channel cycle %0d: det=%b any=%b cnt=%h, want %b %b 1111",
                 i, det, det_any, evt_cnt, (i < 3) ? 4'hF : 4'h0, (i < 3));
      end
    end
  endtask

  task automatic test_abort();
    step(1'b1, 2'b00, 1'b0, 8'h00);
    step(1'b1, 2'b00, 1'b0, 8'h00);
    step(1'b1, 2'b00, 1'b0, {6'b010101, 2'b11});
    step(1'b1, 2'b00, 1'b0, NEU);
    step(1'b0, 2'b00, 1'b0, NEU);
    checks++;
    if (det !== '0 || state !== '0 || evt_cnt !== 16'h1112) begin
      errors++;
      $display("FAIL en_abort: det=%b state=%b cnt=%h, want 0 0 1112", det, state, evt_cnt);
    end
    step(1'b0, 2'b00, 1'b0, NEU);
    step(1'b1, 2'b00, 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (det !== '0 || det_any !== 1'b0 || state !== '0 || evt_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: det=%b state=%b cnt=%h, want all zero", det, state, evt_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 2'b00, 1'b0, 8'hFF);
    step(1'b1, 2'b00, 1'b0, 8'h00);
    checks++;
    if (det !== '0 || state !== 8'h55) begin
      errors++;
      $display("FAIL post_reset_qual: det=%b state=%b, want 0000 01010101", det, state);
    end
    step(1'b1, 2'b00, 1'b0, 8'h00);
    step(1'b1, 2'b00, 1'b0, 8'hFF);
    checks++;
    if (det !== 4'hF || evt_cnt !== 16'h1111) begin
      errors++;
      $display("FAIL post_reset_det: det=%b cnt=%h, want 1111 1111", det, evt_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       e;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 5))
          0, 1, 2: d[c*2 +: 2] = 2'b00;
          3, 4:    d[c*2 +: 2] = 2'b11;
          default: d[c*2 +: 2] = 2'($urandom_range(0, 3));
        endcase
      end
      e = ($urandom_range(0, 19) != 0);
      step(e, 2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0), d);
      checks++;
      if (det !== exp_det() || det_any !== |exp_det() || state !== exp_state() || evt_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL random step %0d: det=%b state=%b cnt=%h, want %b %b %h",
                 i, det, state, evt_cnt, exp_det(), exp_state(), exp_cnt());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rise_basic();
    test_qualification();
    test_fall_both();
    test_saturation_clear();
    test_multi_channel();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
